image_uart_sender: RTL and testbench

- Streams a stored image out of an 8-bit BRAM read port over a UART TX line, pixel by pixel from address 0 upward.
- Mirror of the image UART receiver, which writes incoming bytes into BRAM; this block drains processed BRAM back to the host.
- Sits between the processed-image BRAM and the board TX pin; 8N1 framing, LSB first.

---
 rtl/img_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 83 ++++++++
 rtl/image_uart_sender.sv | 183 ++++++++++++++++++
 tb/tb_image_uart_sender.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// img_pkg: image geometry, UART line defaults and FSM state encodings shared by the
// image sender and its byte transmitter.
package img_pkg;

  localparam int IMG_W        = 128;
  localparam int IMG_H        = 128;
  localparam int NUM_PIXELS   = IMG_W * IMG_H;
  localparam int ADDR_W       = 14;
  localparam int PAD_ADDR_W   = 15;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 115_200;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } send_state_t;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// uart_tx_byte: 8N1 LSB-first transmitter; a load accepted in the last STOP cycle
// chains the next frame with no idle gap.
module uart_tx_byte
  import img_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_frame_end,
  output logic       o_stop_next
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_TICK = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      r_state;
  uart_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_tick;
  logic             w_accept;

  assign w_tick      = (r_cnt == c_TICK);
  assign o_ready     = (r_state == U_IDLE) || ((r_state == U_STOP) && w_tick);
  assign w_accept    = i_load && o_ready;
  assign o_frame_end = (r_state == U_STOP) && w_tick;
  assign o_stop_next = (r_state == U_DATA) && w_tick && (r_bit == 3'd7);
  assign o_tx        = r_tx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      U_IDLE:  if (i_load) w_next = U_START;
      U_START: if (w_tick) w_next = U_DATA;
      U_DATA:  if (o_stop_next) w_next = U_STOP;
      U_STOP:  if (w_tick) w_next = i_load ? U_START : U_IDLE;
      default: w_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= U_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      if ((r_state == U_IDLE) || w_tick) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_shift <= i_data;
        r_tx    <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          U_START: r_tx <= r_shift[0];
          U_DATA: begin
            // r_shift[1] is the bit that becomes current after this shift
            r_shift <= r_shift >> 1;
            r_tx    <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            r_bit   <= r_bit + 1'b1;
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_uart_sender.sv
`default_nettype none
// image_uart_sender: streams BRAM bytes 0..NUM_PIXELS-1 out as gapless 8N1 UART frames.
// Define IMAGE_UART_SENDER_CHECKSUM_EN to append a mod-256 checksum trailer frame.
module image_uart_sender
  import img_pkg::*;
#(
  parameter int CLK_FREQ   = img_pkg::DEF_CLK_FREQ,
  parameter int BAUD       = img_pkg::DEF_BAUD,
  parameter int ADDR_W     = img_pkg::ADDR_W,
  parameter int NUM_PIXELS = img_pkg::NUM_PIXELS,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam int                CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [1:0]        c_LAT_LAST   = 2'(READ_LAT - 1);

  send_state_t       r_state;
  send_state_t       w_next;
  logic              r_start_q;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
  logic              r_hold_vld;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_sent;
  logic [1:0]        r_fcnt;
  logic [7:0]        r_hold;
  logic              w_launch;
  logic              w_more;
  logic              w_load;
  logic              w_ready;
  logic              w_frame_end;
  logic              w_stop_next;
  logic              w_prefetch;
  logic              w_finish;
  logic              w_tr_queue;
  logic              w_tr_done;
  logic              w_count_frame;
  logic [7:0]        w_tr_data;

  assign w_launch   = (r_state == S_IDLE) && start && !r_start_q;
  assign w_more     = (r_addr != c_LAST_ADDR);
  assign w_load     = r_hold_vld && w_ready;
  // the next byte is fetched while the current frame sits in its stop bit
  assign w_prefetch = (r_state == S_SEND) && w_stop_next && w_more;
  assign w_finish   = (r_state == S_SEND) && w_frame_end && !r_hold_vld && !w_more && w_tr_done;

`ifdef IMAGE_UART_SENDER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_trailer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_trailer <= 1'b0;
    end else if (w_launch) begin
      r_sum     <= '0;
      r_trailer <= 1'b0;
    end else begin
      if (r_state == S_LOAD) r_sum <= r_sum + bram_dout;
      if (w_tr_queue)        r_trailer <= 1'b1;
    end
  end

  assign w_tr_queue    = (r_state == S_SEND) && w_stop_next && !w_more && !r_trailer;
  assign w_tr_done     = r_trailer;
  assign w_tr_data     = r_sum;
  // the trailer is the only frame that ends with nothing queued behind it once armed
  assign w_count_frame = !(r_trailer && !r_hold_vld);
`else
  assign w_tr_queue    = 1'b0;
  assign w_tr_done     = 1'b1;
  assign w_tr_data     = 8'h00;
  assign w_count_frame = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_FETCH;
      S_FETCH: if (r_fcnt == c_LAT_LAST) w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND: begin
        if (w_prefetch)    w_next = S_FETCH;
        else if (w_finish) w_next = S_DONE;
      end
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q  <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hold_vld <= 1'b0;
      r_addr     <= '0;
      r_sent     <= '0;
      r_fcnt     <= '0;
      r_hold     <= '0;
    end else begin
      r_start_q <= start;

      if (w_launch) begin
        r_en       <= 1'b1;
        r_addr     <= '0;
        r_fcnt     <= '0;
        r_busy     <= 1'b1;
        r_sent     <= '0;
        r_hold_vld <= 1'b0;
      end else if (w_prefetch) begin
        r_en   <= 1'b1;
        r_addr <= r_addr + 1'b1;
        r_fcnt <= '0;
      end else if (r_state == S_FETCH) begin
        r_fcnt <= r_fcnt + 1'b1;
        if (r_fcnt == c_LAT_LAST) r_en <= 1'b0;
      end

      if (r_state == S_LOAD) begin
        r_hold     <= bram_dout;
        r_hold_vld <= 1'b1;
      end else if (w_tr_queue) begin
        r_hold     <= w_tr_data;
        r_hold_vld <= 1'b1;
      end else if (w_load) begin
        r_hold_vld <= 1'b0;
      end

      if (w_frame_end && w_count_frame) r_sent <= r_sent + 1'b1;

      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end

      if ((r_state == S_DONE) && !start) begin
        r_done <= 1'b0;
        r_addr <= '0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (r_hold),
    .o_tx       (tx),
    .o_ready    (w_ready),
    .o_frame_end(w_frame_end),
    .o_stop_next(w_stop_next)
  );

  assign bram_en   = r_en;
  assign bram_addr = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sent_cnt  = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_image_uart_sender.sv
`default_nettype none
// tb_image_uart_sender: two senders (read latency 1 and 3) fed by BRAM models; the serial
// line is decoded at mid-bit and compared with a byte-stream model built from memory contents.
module tb_image_uart_sender;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int NPIX     = 4;
  localparam int AW       = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    start;
  logic [1:0]    clr;
  logic [1:0]    bram_en;
  logic [1:0]    tx;
  logic [1:0]    busy;
  logic [1:0]    done;
  logic [AW-1:0] bram_addr [2];
  logic [7:0]    bram_dout [2];
  logic [AW:0]   sent_cnt  [2];
  logic [7:0]    mem [2][NPIX];
  logic [7:0]    exp_q [$];
  int            cyc = 0;
  int            npass = 0;
  int            nfail = 0;
  int            nchk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] pipe [LAT];
    logic       en_q;
    int         fetches;
    int         bad;

    image_uart_sender #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .ADDR_W    (AW),
      .NUM_PIXELS(NPIX),
      .READ_LAT  (LAT)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .bram_en  (bram_en[g]),
      .bram_addr(bram_addr[g]),
      .bram_dout(bram_dout[g]),
      .tx       (tx[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .sent_cnt (sent_cnt[g])
    );

    always @(posedge clk) begin
      if (bram_en[g]) pipe[0] <= mem[g][int'(bram_addr[g]) % NPIX];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      en_q <= bram_en[g];
      if (clr[g]) begin
        fetches <= 0;
        bad     <= 0;
      end else if (bram_en[g] && !en_q) begin
        if (int'(bram_addr[g]) != fetches) bad <= bad + 1;
        fetches <= fetches + 1;
      end
    end
    assign bram_dout[g] = pipe[LAT-1];
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int fetches_of(input int i);
    return (i == 0) ? g_dut[0].fetches : g_dut[1].fetches;
  endfunction

  function automatic int bad_of(input int i);
    return (i == 0) ? g_dut[0].bad : g_dut[1].bad;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference: pixels in address order, then (optionally) their mod-256 sum
  task automatic build_exp(input int i);
    int sum;
    sum = 0;
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
      exp_q.push_back(mem[i][k]);
      sum += int'(mem[i][k]);
    end
`ifdef IMAGE_UART_SENDER_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endtask

  task automatic set_mem(input int i, input logic [31:0] w);
    for (int k = 0; k < NPIX; k++) mem[i][k] = w[8*(3-k) +: 8];
  endtask

  task automatic launch(input int i, output int t0);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic run_xfer(input int i, input bit toggle, input string tag);
    int         t0;
    int         s;
    int         nf;
    int         lat;
    logic [7:0] got;
    logic       bad_frame;
    logic       quiet;
    lat = lat_of(i);
    build_exp(i);
    nf = exp_q.size();
    clr[i] = 1'b1;
    @(posedge clk);
    #1;
    clr[i] = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy[i]), 32'd0);
    launch(i, t0);
    chk({tag, "_en_first"}, 32'(bram_en[i]), 32'd1);
    chk({tag, "_addr_first"}, 32'(bram_addr[i]), 32'd0);
    chk({tag, "_busy_first"}, 32'(busy[i]), 32'd1);
    wait_to(t0 + lat + 1);
    chk({tag, "_tx_before_start"}, 32'(tx[i]), 32'd1);
    s = t0 + lat + 2;
    for (int f = 0; f < nf; f++) begin
      wait_to(s + f * FRAME);
      chk({tag, "_frame_edge"}, 32'(tx[i]), 32'd0);
      chk({tag, "_sent_mid"}, 32'(sent_cnt[i]), 32'((f < NPIX) ? f : NPIX));
      got = '0;
      bad_frame = 1'b0;
      for (int b = 0; b < 10; b++) begin
        wait_to(s + f * FRAME + b * CPB + CPB / 2);
        if (b == 0)      bad_frame = bad_frame | (tx[i] != 1'b0);
        else if (b == 9) bad_frame = bad_frame | (tx[i] != 1'b1);
        else             got[b-1] = tx[i];
        if (toggle && f == 1 && b == 3) start[i] = 1'b0;
        if (toggle && f == 1 && b == 6) start[i] = 1'b1;
      end
      chk({tag, "_byte"}, 32'(got), 32'(exp_q[f]));
      chk({tag, "_framing"}, 32'(bad_frame), 32'd0);
    end
    wait_to(s + nf * FRAME - 1);
    chk({tag, "_busy_last_stop"}, 32'({busy[i], done[i]}), 32'b10);
    wait_to(s + nf * FRAME);
    chk({tag, "_finish_flags"}, 32'({busy[i], done[i]}), 32'b01);
    chk({tag, "_sent_final"}, 32'(sent_cnt[i]), 32'(NPIX));
    quiet = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      wait_to(cyc + 1);
      quiet = quiet & tx[i] & done[i] & !bram_en[i];
    end
    chk({tag, "_hold_quiet"}, 32'(quiet), 32'd1);
    chk({tag, "_fetch_count"}, 32'(fetches_of(i)), 32'(NPIX));
    chk({tag, "_fetch_order"}, 32'(bad_of(i)), 32'd0);
    @(negedge clk);
    start[i] = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_clear"}, 32'(done[i]), 32'd0);
    chk({tag, "_sent_held"}, 32'(sent_cnt[i]), 32'(NPIX));
    chk({tag, "_addr_rewind"}, 32'(bram_addr[i]), 32'd0);
  endtask

  task automatic reset_mid(input int i);
    int t0;
    int s;
    launch(i, t0);
    s = t0 + lat_of(i) + 2;
    // data bit 2 of the second byte; chosen so the line is low when reset hits
    wait_to(s + FRAME + 3 * CPB + CPB / 2);
    chk("rst_pre_tx", 32'(tx[i]), 32'(mem[i][1][2]));
    chk("rst_pre_sent", 32'(sent_cnt[i]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx[i]), 32'd1);
    chk("rst_async_busy", 32'(busy[i]), 32'd0);
    chk("rst_async_sent", 32'(sent_cnt[i]), 32'd0);
    chk("rst_async_en", 32'(bram_en[i]), 32'd0);
    @(negedge clk);
    start[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    start = '0;
    clr   = '0;
    set_mem(0, 32'h55A300FF);
    set_mem(1, 32'h55A300FF);
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_tx", 32'(tx[i]), 32'd1);
      chk("reset_flags", 32'({busy[i], done[i], bram_en[i]}), 32'd0);
      chk("reset_addr", 32'(bram_addr[i]), 32'd0);
      chk("reset_sent", 32'(sent_cnt[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xfer(0, 1'b0, "lat1");
    run_xfer(1, 1'b0, "lat3");
    run_xfer(0, 1'b1, "toggle");
    reset_mid(0);
    run_xfer(0, 1'b0, "post_reset");
    set_mem(1, 32'h80901001);
    run_xfer(1, 1'b0, "sumset");

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin
        set_mem(i, $urandom);
        run_xfer(i, 1'(r), "random");
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
